// File: rtl/slc3_mem_responder.sv
// slc3_mem_responder: wait-stated SLC-3 word memory with switch/hex I/O word; `define MEM_BOUNDS_CHECK_EN to reject out-of-range addresses
module slc3_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_WAIT = 1,
    parameter int WRITE_WAIT = 3,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input logic Clk,
    input logic Reset,
    input logic Mem_OE,
    input logic Mem_WE,
    input logic [15:0] ADDR,
    input logic [15:0] Data_from_CPU,
    input logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic Data_valid,
    output logic Busy,
    output logic [15:0] HEX_out,
    output logic Err
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_HOLD, WR_WAIT, CONFLICT} state_t;
    localparam logic [3:0] RW = 4'(READ_WAIT);
    localparam logic [3:0] WW = 4'(WRITE_WAIT);
    state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [3:0] cnt_inc;
    logic [15:0] addr_q, data_q, acc_addr, acc_data;
    logic load, commit, err_n, io_hit, oob;
    logic [DEPTH_LOG2-1:0] idx;
    logic [15:0] mem [2**DEPTH_LOG2];

    // in IDLE the access starts this cycle, so the live bus is used instead of the latches
    assign acc_addr = (state == IDLE) ? ADDR : addr_q;
    assign acc_data = (state == IDLE) ? Data_from_CPU : data_q;
    assign idx = acc_addr[DEPTH_LOG2-1:0];
    assign io_hit = acc_addr == IO_ADDR;
    assign cnt_inc = {1'b0, cnt} + 4'd1;
    assign Busy = state != IDLE;
`ifdef MEM_BOUNDS_CHECK_EN
    assign oob = !io_hit && (acc_addr >> DEPTH_LOG2) != 16'd0;
`else
    assign oob = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        load = 1'b0;
        commit = 1'b0;
        err_n = 1'b0;
        if (Mem_OE && Mem_WE) begin
            state_n = CONFLICT;
            err_n = state != CONFLICT;
        end else begin
            case (state)
                IDLE: begin
                    if (Mem_OE) begin
                        cnt_n = 3'd1;
                        load = RW <= 4'd1;
                        state_n = load ? RD_HOLD : RD_WAIT;
                    end else if (Mem_WE) begin
                        cnt_n = 3'd1;
                        commit = WW <= 4'd1;
                        state_n = commit ? IDLE : WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (!Mem_OE) state_n = IDLE;
                    else begin
                        cnt_n = cnt_inc[2:0];
                        load = cnt_inc >= RW;
                        state_n = load ? RD_HOLD : RD_WAIT;
                    end
                end
                RD_HOLD: state_n = Mem_OE ? RD_HOLD : IDLE;
                WR_WAIT: begin
                    if (!Mem_WE) begin
                        state_n = IDLE;
                        err_n = 1'b1;
                    end else begin
                        cnt_n = cnt_inc[2:0];
                        commit = cnt_inc >= WW;
                        state_n = commit ? IDLE : WR_WAIT;
                    end
                end
                CONFLICT: state_n = (Mem_OE || Mem_WE) ? CONFLICT : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            cnt <= 3'd0;
            addr_q <= 16'd0;
            data_q <= 16'd0;
            Data_to_CPU <= 16'd0;
            Data_valid <= 1'b0;
            HEX_out <= 16'd0;
            Err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            Err <= err_n | ((load | commit) & oob);
            Data_valid <= state_n == RD_HOLD;
            if (state == IDLE) begin
                addr_q <= ADDR;
                data_q <= Data_from_CPU;
            end
            if (load) Data_to_CPU <= io_hit ? Switches : oob ? 16'd0 : mem[idx];
            if (commit && io_hit) HEX_out <= acc_data;
        end
    end

    always_ff @(posedge Clk)
        if (Reset && commit && !io_hit && !oob) mem[idx] <= acc_data;
endmodule

// File: tb/tb_slc3_mem_responder.sv
// tb_slc3_mem_responder: directed scoreboard bench for slc3_mem_responder
module tb_slc3_mem_responder;
    logic Clk = 1'b0;
    logic Reset, Mem_OE, Mem_WE, Data_valid, Busy, Err;
    logic [15:0] ADDR, Data_from_CPU, Switches, Data_to_CPU, HEX_out;
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] sb [$];

    slc3_mem_responder dut (
        .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
        .Data_from_CPU(Data_from_CPU), .Switches(Switches), .Data_to_CPU(Data_to_CPU),
        .Data_valid(Data_valid), .Busy(Busy), .HEX_out(HEX_out), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input logic exp_err);
        int n;
        logic [15:0] want;
        ADDR = a;
        Mem_OE = 1'b1;
        sb.push_back(exp);
        tick();
        n = 1;
        while (!Data_valid && n < 8) begin
            tick();
            n++;
        end
        chk("rd_latency", 16'(n), 16'd1);
        chk("rd_err", {15'd0, Err}, {15'd0, exp_err});
        want = sb.size() > 0 ? sb.pop_front() : 16'hxxxx;
        chk("rd_data", Data_to_CPU, want);
        ADDR = 16'h0000;
        tick();
        chk("rd_hold_valid", {15'd0, Data_valid}, 16'd1);
        chk("rd_hold_data", Data_to_CPU, want);
        Mem_OE = 1'b0;
        tick();
        chk("rd_release_valid", {15'd0, Data_valid}, 16'd0);
        chk("rd_release_data", Data_to_CPU, want);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        Data_from_CPU = d;
        Mem_WE = 1'b1;
        tick();
        ADDR = 16'h0001;
        Data_from_CPU = 16'hDEAD;
        chk("wr_busy1", {15'd0, Busy}, 16'd1);
        tick();
        chk("wr_busy2", {15'd0, Busy}, 16'd1);
        tick();
        chk("wr_done_busy", {15'd0, Busy}, 16'd0);
        chk("wr_err", {15'd0, Err}, 16'd0);
        Mem_WE = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b0;
        Mem_OE = 1'b0;
        Mem_WE = 1'b0;
        ADDR = 16'h0000;
        Data_from_CPU = 16'h0000;
        Switches = 16'h0000;
        tick();
        tick();
        chk("rst_data", Data_to_CPU, 16'h0000);
        chk("rst_valid", {15'd0, Data_valid}, 16'd0);
        chk("rst_busy", {15'd0, Busy}, 16'd0);
        chk("rst_hex", HEX_out, 16'h0000);
        chk("rst_err", {15'd0, Err}, 16'd0);
        Reset = 1'b1;
        tick();

        wr(16'h0012, 16'hBEEF);
        rd(16'h0012, 16'hBEEF, 1'b0);
        wr(16'h0020, 16'h1111);
        wr(16'h03FF, 16'hCAFE);
        rd(16'h0020, 16'h1111, 1'b0);

        Switches = 16'h00A5;
        rd(16'hFFFF, 16'h00A5, 1'b0);
        Switches = 16'h0000;
        wr(16'hFFFF, 16'h1234);
        chk("hex_write", HEX_out, 16'h1234);
        rd(16'h03FF, 16'hCAFE, 1'b0);

        ADDR = 16'h0020;
        Data_from_CPU = 16'h5555;
        Mem_WE = 1'b1;
        tick();
        tick();
        chk("abort_no_err_yet", {15'd0, Err}, 16'd0);
        Mem_WE = 1'b0;
        tick();
        chk("abort_err", {15'd0, Err}, 16'd1);
        tick();
        chk("abort_err_clear", {15'd0, Err}, 16'd0);
        rd(16'h0020, 16'h1111, 1'b0);

        ADDR = 16'h0012;
        Data_from_CPU = 16'h0BAD;
        Mem_OE = 1'b1;
        Mem_WE = 1'b1;
        tick();
        chk("conflict_err", {15'd0, Err}, 16'd1);
        chk("conflict_busy", {15'd0, Busy}, 16'd1);
        Mem_OE = 1'b0;
        tick();
        chk("conflict_err_clear", {15'd0, Err}, 16'd0);
        chk("conflict_hold", {15'd0, Busy}, 16'd1);
        tick();
        chk("conflict_hold2", {15'd0, Busy}, 16'd1);
        Mem_WE = 1'b0;
        tick();
        chk("conflict_exit", {15'd0, Busy}, 16'd0);
        rd(16'h0012, 16'hBEEF, 1'b0);

        ADDR = 16'h0012;
        Data_from_CPU = 16'h7777;
        Mem_WE = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        chk("mid_rst_busy", {15'd0, Busy}, 16'd0);
        chk("mid_rst_data", Data_to_CPU, 16'h0000);
        chk("mid_rst_hex", HEX_out, 16'h0000);
        chk("mid_rst_valid", {15'd0, Data_valid}, 16'd0);
        chk("mid_rst_err", {15'd0, Err}, 16'd0);
        Reset = 1'b1;
        Mem_WE = 1'b0;
        tick();
        rd(16'h0012, 16'hBEEF, 1'b0);

`ifdef MEM_BOUNDS_CHECK_EN
        rd(16'h0412, 16'h0000, 1'b1);
        chk("oob_err_clear", {15'd0, Err}, 16'd0);
`else
        rd(16'h0412, 16'hBEEF, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
